// File: rtl/hash_serializer.sv
// Buffers 256-bit heavy-hash results in a circular FIFO and streams each one
// to the comparator as four 64-bit words, most-significant word first.
module hash_serializer #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stop,
    input  logic [255:0] hash_in,
    input  logic         hash_in_valid,
    output logic         hash_in_ready,
    input  logic         heavy_hash_re,
    output logic [63:0]  heavy_hash_dout,
    output logic         heavy_hash_dout_we,
    output logic         overflow,
    output logic [31:0]  hashes_accepted
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    logic [255:0]  mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    idx_q, idx_d;
    logic [63:0]   dout_q, dout_d;
    logic          we_q, we_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   accepted_q, accepted_d;

    logic          push;
    logic          pop;
    logic [255:0]  head;
    logic [63:0]   head_word;

    assign hash_in_ready      = (count_q < FULL_COUNT);
    assign heavy_hash_dout    = dout_q;
    assign heavy_hash_dout_we = we_q;
    assign overflow           = overflow_q;
    assign hashes_accepted    = accepted_q;

    assign head = mem[rd_ptr_q];

    always_comb begin
        head_word = head[255:192];
        case (idx_q)
            2'd0:    head_word = head[255:192];
            2'd1:    head_word = head[191:128];
            2'd2:    head_word = head[127:64];
            default: head_word = head[63:0];
        endcase
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= hash_in;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        idx_d      = idx_q;
        dout_d     = dout_q;
        we_d       = 1'b0;
        overflow_d = overflow_q;
        accepted_d = accepted_q;
        push       = 1'b0;
        pop        = 1'b0;

        if (stop) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            idx_d    = 2'd0;
        end else begin
            push = hash_in_valid && hash_in_ready;
            if (hash_in_valid && !hash_in_ready) begin
                overflow_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d   = wr_ptr_q + AW'(1);
                accepted_d = accepted_q + 32'd1;
            end

            case (state_q)
                IDLE: begin
                    idx_d = 2'd0;
                    if (count_q != '0) begin
                        state_d = STREAM;
                    end
                end
                default: begin
                    if (heavy_hash_re && (count_q != '0)) begin
                        dout_d = head_word;
                        we_d   = 1'b1;
                        idx_d  = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            pop      = 1'b1;
                            rd_ptr_d = rd_ptr_q + AW'(1);
                        end
                    end
                end
            endcase

            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            // Stay in STREAM across hashes so a held read enable sees no bubble.
            if (pop) begin
                state_d = (count_d != '0) ? STREAM : IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= 2'd0;
            dout_q     <= '0;
            we_q       <= 1'b0;
            overflow_q <= 1'b0;
            accepted_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            dout_q     <= dout_d;
            we_q       <= we_d;
            overflow_q <= overflow_d;
            accepted_q <= accepted_d;
        end
    end

endmodule

// File: tb/tb_hash_serializer.sv
// Self-checking bench for hash_serializer: expected words are queued when a
// hash is pushed and compared as the DUT emits them.
module tb_hash_serializer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stop = 1'b0;
    logic [255:0] hash_in = '0;
    logic         hash_in_valid = 1'b0;
    logic         hash_in_ready;
    logic         heavy_hash_re = 1'b0;
    logic [63:0]  heavy_hash_dout;
    logic         heavy_hash_dout_we;
    logic         overflow;
    logic [31:0]  hashes_accepted;

    int           n_vec = 0;
    int           n_err = 0;
    logic [63:0]  exp_q [$];

    hash_serializer #(.DEPTH(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .stop               (stop),
        .hash_in            (hash_in),
        .hash_in_valid      (hash_in_valid),
        .hash_in_ready      (hash_in_ready),
        .heavy_hash_re      (heavy_hash_re),
        .heavy_hash_dout    (heavy_hash_dout),
        .heavy_hash_dout_we (heavy_hash_dout_we),
        .overflow           (overflow),
        .hashes_accepted    (hashes_accepted)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] rand_hash();
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom;
        return h;
    endfunction

    task automatic monitor();
        logic [63:0] e;
        logic [63:0] last = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = '0;
            end else if (heavy_hash_dout_we) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL word_out: got %h, no word expected", heavy_hash_dout);
                end else begin
                    e = exp_q.pop_front();
                    if (heavy_hash_dout !== e) begin
                        n_err++;
                        $display("FAIL word_out: got %h, expected %h", heavy_hash_dout, e);
                    end else begin
                        $display("word %h ok", heavy_hash_dout);
                    end
                end
                last = heavy_hash_dout;
            end else begin
                n_vec++;
                if (heavy_hash_dout !== last) begin
                    n_err++;
                    $display("FAIL dout_hold: got %h, expected %h", heavy_hash_dout, last);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stop = 1'b0;
        hash_in_valid = 1'b0;
        heavy_hash_re = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drive_push(input logic [255:0] h, input bit accept);
        hash_in = h;
        hash_in_valid = 1'b1;
        @(posedge clk);
        #1;
        hash_in_valid = 1'b0;
        if (accept) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(h[255 - 64*i -: 64]);
        end
        $display("push %h accept=%0d", h[255:192], accept);
    endtask

    task automatic wait_size(input int target, input string name);
        bit hit = 0;
        for (int c = 0; c < 60 && !hit; c++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == target) hit = 1;
        end
        n_vec++;
        if (exp_q.size() != target) begin
            n_err++;
            $display("FAIL %s: queue depth %0d, expected %0d", name, exp_q.size(), target);
        end
    endtask

    task automatic wait_drain(input string name);
        wait_size(0, name);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check32("reset_we", {31'd0, heavy_hash_dout_we}, 32'd0);
        check32("reset_dout_lo", heavy_hash_dout[31:0], 32'd0);
        check32("reset_dout_hi", heavy_hash_dout[63:32], 32'd0);
        check32("reset_overflow", {31'd0, overflow}, 32'd0);
        check32("reset_accepted", hashes_accepted, 32'd0);
        check32("reset_ready", {31'd0, hash_in_ready}, 32'd1);
    endtask

    task automatic test_basic_stream();
        do_reset();
        heavy_hash_re = 1'b1;
        drive_push({64'h1111111111111111, 64'h2222222222222222,
                    64'h3333333333333333, 64'h4444444444444444}, 1);
        wait_drain("basic_drain");
        check32("basic_accepted", hashes_accepted, 32'd1);
        heavy_hash_re = 1'b0;
    endtask

    task automatic test_alternating();
        int  pulses = 0;
        bit  prev = 0;
        bit  consec = 0;
        do_reset();
        drive_push(rand_hash(), 1);
        for (int k = 0; k < 16; k++) begin
            heavy_hash_re = (k % 2 == 0);
            @(negedge clk);
            #1;
            if (heavy_hash_dout_we) begin
                pulses++;
                if (prev) consec = 1;
            end
            prev = heavy_hash_dout_we;
            @(posedge clk);
            #1;
        end
        heavy_hash_re = 1'b0;
        check32("alt_pulses", pulses, 32'd4);
        check32("alt_consecutive", {31'd0, consec}, 32'd0);
        wait_drain("alt_drain");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 3; i++) drive_push(rand_hash(), 1);
        check32("ovf_ready_at3", {31'd0, hash_in_ready}, 32'd1);
        drive_push(rand_hash(), 1);
        check32("ovf_ready_at4", {31'd0, hash_in_ready}, 32'd0);
        drive_push(rand_hash(), 0);
        check32("ovf_flag", {31'd0, overflow}, 32'd1);
        check32("ovf_accepted", hashes_accepted, 32'd4);
        heavy_hash_re = 1'b1;
        wait_drain("ovf_drain");
        check32("ovf_sticky", {31'd0, overflow}, 32'd1);
        heavy_hash_re = 1'b0;
    endtask

    task automatic test_stop();
        do_reset();
        heavy_hash_re = 1'b1;
        drive_push(rand_hash(), 1);
        wait_size(2, "stop_two_words");
        stop = 1'b1;
        hash_in = rand_hash();
        hash_in_valid = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        hash_in_valid = 1'b0;
        exp_q.delete();
        check32("stop_we", {31'd0, heavy_hash_dout_we}, 32'd0);
        check32("stop_accepted", hashes_accepted, 32'd1);
        check32("stop_overflow", {31'd0, overflow}, 32'd0);
        check32("stop_ready", {31'd0, hash_in_ready}, 32'd1);
        drive_push(rand_hash(), 1);
        wait_drain("stop_drain");
        check32("stop_accepted_after", hashes_accepted, 32'd2);
        heavy_hash_re = 1'b0;
    endtask

    task automatic test_full_pop_push();
        do_reset();
        for (int i = 0; i < 4; i++) drive_push(rand_hash(), 1);
        heavy_hash_re = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        // Final word of the head leaves on the next edge while full.
        drive_push(rand_hash(), 0);
        check32("full_pop_overflow", {31'd0, overflow}, 32'd1);
        check32("full_pop_accepted", hashes_accepted, 32'd4);
        check32("full_pop_ready", {31'd0, hash_in_ready}, 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        drive_push(rand_hash(), 1);
        heavy_hash_re = 1'b0;
        check32("occ3_accepted", hashes_accepted, 32'd5);
        check32("occ3_ready", {31'd0, hash_in_ready}, 32'd1);
        drive_push(rand_hash(), 1);
        check32("occ3_then_full", {31'd0, hash_in_ready}, 32'd0);
        heavy_hash_re = 1'b1;
        wait_drain("full_pop_drain");
        check32("full_pop_total", hashes_accepted, 32'd6);
        heavy_hash_re = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit seen = 0;
        do_reset();
        drive_push(rand_hash(), 1);
        drive_push(rand_hash(), 1);
        heavy_hash_re = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (heavy_hash_dout_we) seen = 1;
        end
        check32("b2b_start", {31'd0, seen}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (heavy_hash_dout_we !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_bubble: we=%0b at word %0d, expected 1", heavy_hash_dout_we, i);
            end
        end
        wait_drain("b2b_drain");
        heavy_hash_re = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        heavy_hash_re = 1'b1;
        drive_push(rand_hash(), 1);
        wait_size(2, "arst_two_words");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check32("arst_we", {31'd0, heavy_hash_dout_we}, 32'd0);
        check32("arst_dout_lo", heavy_hash_dout[31:0], 32'd0);
        check32("arst_dout_hi", heavy_hash_dout[63:32], 32'd0);
        check32("arst_accepted", hashes_accepted, 32'd0);
        check32("arst_ready", {31'd0, hash_in_ready}, 32'd1);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_push(rand_hash(), 1);
        wait_drain("arst_restart");
        check32("arst_accepted_after", hashes_accepted, 32'd1);
        heavy_hash_re = 1'b0;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic_stream();
        test_alternating();
        test_overflow();
        test_stop();
        test_full_pop_push();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
